// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the CPU datapath:
// state and owner encodings plus the default memory geometry.
package mem_arbiter_pkg;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CPU        = 2'd1,
    ST_DMA        = 2'd2,
    ST_DMA_LOCKED = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared synchronous instruction/data memory.
// The CPU datapath and a DMA/program-loader master share one access per
// cycle. DMA may lock the port for bursts of up to MAX_BURST beats, after
// which the CPU is guaranteed a beat if it is waiting.
// Optional feature: define MEM_ARB_RR_EN for round-robin between the two
// masters on contention; otherwise the CPU has fixed priority over DMA.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW        = MEM_AW,
  parameter int unsigned DW        = MEM_DW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rd_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned    BCW       = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);

  arb_state_e     state_q, state_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic           cpu_rvalid_q, cpu_rvalid_d;
  logic           dma_rvalid_q, dma_rvalid_d;
  logic           lock_cont;
  logic           forced_rel;
  logic           dma_elig;

`ifdef MEM_ARB_RR_EN
  arb_owner_e     last_owner_q, last_owner_d;
`endif

  // Burst bookkeeping: continuation, forced release and DMA eligibility.
  always_comb begin
    lock_cont  = (state_q == ST_DMA_LOCKED) && dma_req && dma_lock &&
                 (burst_cnt_q < BURST_MAX);
    forced_rel = (state_q == ST_DMA_LOCKED) && (burst_cnt_q == BURST_MAX);
    // After a full-length burst the waiting CPU gets the next beat.
    dma_elig   = dma_req && !(forced_rel && cpu_req);
  end

  // Grant selection and next-state computation.
  always_comb begin
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    state_d      = ST_IDLE;
    burst_cnt_d  = '0;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif

    if (lock_cont) begin
      dma_gnt = 1'b1;
    end else if (cpu_req && dma_elig) begin
`ifdef MEM_ARB_RR_EN
      if (last_owner_q == OWN_CPU) dma_gnt = 1'b1;
      else                         cpu_gnt = 1'b1;
`else
      cpu_gnt = 1'b1;
`endif
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dma_elig) begin
      dma_gnt = 1'b1;
    end

    if (cpu_gnt) begin
      state_d = ST_CPU;
    end else if (dma_gnt) begin
      state_d = dma_lock ? ST_DMA_LOCKED : ST_DMA;
    end

    // A locked grant either extends the running burst or starts a new one.
    if (dma_gnt && dma_lock) begin
      burst_cnt_d = lock_cont ? burst_cnt_q + BCW'(1) : BCW'(1);
    end

`ifdef MEM_ARB_RR_EN
    if (cpu_gnt)      last_owner_d = OWN_CPU;
    else if (dma_gnt) last_owner_d = OWN_DMA;
`endif

    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dma_rvalid_d = dma_gnt && !dma_we;
  end

  // Memory port mux and CPU stall.
  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
    cpu_stall  = cpu_req & ~cpu_gnt;
    cpu_rvalid = cpu_rvalid_q;
    dma_rvalid = dma_rvalid_q;
    rd_data    = mem_rdata;
  end

  // State, burst counter and read-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last served master; survives idle cycles so round-robin stays fair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_owner_q <= OWN_DMA;
    else       last_owner_q <= last_owner_d;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default MAX_BURST=4) plus a
// MAX_BURST=1 instance sharing the same stimulus.
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;

  logic          cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  logic          cpu_gnt_1, cpu_rvalid_1, cpu_stall_1, dma_gnt_1, dma_rvalid_1;
  logic [DW-1:0] rd_data_1, mem_wdata_1;
  logic          mem_en_1, mem_we_1;
  logic [AW-1:0] mem_addr_1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_1), .cpu_rvalid(cpu_rvalid_1), .cpu_stall(cpu_stall_1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_1), .dma_rvalid(dma_rvalid_1), .rd_data(rd_data_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata)
  );

  // Synchronous memory model: address 0x10 preloaded with 0x1234.
  logic [DW-1:0] mem_arr [256];
  bit   [255:0]  written;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem_arr[mem_addr] <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? mem_arr[mem_addr] :
                     (mem_addr == 8'h10) ? 16'h1234 : 16'h0000;
      end
    end
  end

  task automatic clear_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall, mem_en, mem_we} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b exp 0000000", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall, mem_en, mem_we}); end
    n_checks++; if ({mem_addr, mem_wdata} !== 24'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: got %h exp 000000", {mem_addr, mem_wdata}); end
    reset = 1'b0;
  endtask

  task automatic test_cpu_read;
    @(negedge clk);
    cpu_req = 1; cpu_addr = 8'h10; #1;
    n_checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL rd_grant: got cpu=%b dma=%b stall=%b exp 1 0 0", cpu_gnt, dma_gnt, cpu_stall); end
    n_checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin
      n_fail++; $display("FAIL rd_mem_port: got en=%b we=%b addr=%h exp 1 0 10", mem_en, mem_we, mem_addr); end
    @(negedge clk);
    clear_inputs(); #1;
    n_checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_rvalid: got cpu=%b dma=%b exp 1 0", cpu_rvalid, dma_rvalid); end
    n_checks++; if (rd_data !== 16'h1234) begin
      n_fail++; $display("FAIL rd_data: got %h exp 1234", rd_data); end
    @(negedge clk); #1;
    n_checks++; if (cpu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rd_rvalid_drop: got %b exp 0", cpu_rvalid); end
  endtask

  task automatic test_contention;
    bit exp_c;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_req = 1; cpu_addr = 8'h01; dma_req = 1; dma_addr = 8'h02; #1;
      exp_c = RR ? (i % 2 == 0) : 1'b1;
      n_checks++; if (cpu_gnt !== exp_c || dma_gnt !== !exp_c) begin
        n_fail++; $display("FAIL contend_%0d: got cpu=%b dma=%b exp cpu=%b dma=%b", i, cpu_gnt, dma_gnt, exp_c, !exp_c); end
      n_checks++; if (mem_addr !== (exp_c ? 8'h01 : 8'h02) || cpu_stall !== !exp_c) begin
        n_fail++; $display("FAIL contend_port_%0d: got addr=%h stall=%b exp addr=%h stall=%b", i, mem_addr, cpu_stall, exp_c ? 8'h01 : 8'h02, !exp_c); end
    end
    clear_inputs();
  endtask

  task automatic test_locked_burst;
    bit cpu_v  [6] = '{0, 1, 1, 1, 1, 0};
    bit e_dma  [6] = '{1, 1, 1, 1, 0, 1};
    bit e_cpu  [6] = '{0, 0, 0, 0, 1, 0};
    bit e_stl  [6] = '{0, 1, 1, 1, 0, 0};
    bit e_drv  [6] = '{0, 1, 1, 1, 1, 0};
    bit e_crv  [6] = '{0, 0, 0, 0, 0, 1};
    bit e_dma1 [2] = '{1, 0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      dma_req = 1; dma_lock = 1; dma_addr = 8'h30 + 8'(c);
      cpu_req = cpu_v[c]; cpu_addr = 8'h40; #1;
      n_checks++; if (dma_gnt !== e_dma[c] || cpu_gnt !== e_cpu[c] || cpu_stall !== e_stl[c]) begin
        n_fail++; $display("FAIL burst_%0d: got dma=%b cpu=%b stall=%b exp %b %b %b", c, dma_gnt, cpu_gnt, cpu_stall, e_dma[c], e_cpu[c], e_stl[c]); end
      n_checks++; if (dma_rvalid !== e_drv[c] || cpu_rvalid !== e_crv[c]) begin
        n_fail++; $display("FAIL burst_rvalid_%0d: got dma=%b cpu=%b exp %b %b", c, dma_rvalid, cpu_rvalid, e_drv[c], e_crv[c]); end
      if (c < 2) begin
        n_checks++; if (dma_gnt_1 !== e_dma1[c] || cpu_gnt_1 !== !e_dma1[c]) begin
          n_fail++; $display("FAIL burst1_%0d: got dma=%b cpu=%b exp %b %b", c, dma_gnt_1, cpu_gnt_1, e_dma1[c], !e_dma1[c]); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_lock_drop;
    bit cpu_v  [8] = '{0, 1, 1, 0, 1, 1, 1, 1};
    bit lock_v [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
    bit e_dma  [8] = '{1, 1, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      dma_req = 1; dma_lock = lock_v[c]; dma_addr = 8'h50;
      cpu_req = cpu_v[c]; cpu_addr = 8'h51; #1;
      n_checks++; if (dma_gnt !== e_dma[c] || cpu_gnt !== !e_dma[c]) begin
        n_fail++; $display("FAIL lockdrop_%0d: got dma=%b cpu=%b exp %b %b", c, dma_gnt, cpu_gnt, e_dma[c], !e_dma[c]); end
    end
    clear_inputs();
  endtask

  task automatic test_write_read;
    int we_pulses = 0;
    do_reset();
    @(negedge clk);
    dma_req = 1; dma_we = 1; dma_addr = 8'h20; dma_wdata = 16'hBEEF; #1;
    if (mem_we === 1'b1) we_pulses++;
    n_checks++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_port: got gnt=%b we=%b addr=%h data=%h exp 1 1 20 beef", dma_gnt, mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    clear_inputs(); cpu_req = 1; cpu_addr = 8'h20; #1;
    if (mem_we === 1'b1) we_pulses++;
    n_checks++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || dma_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_then_rd: got gnt=%b we=%b dma_rvalid=%b exp 1 0 0", cpu_gnt, mem_we, dma_rvalid); end
    @(negedge clk);
    clear_inputs(); #1;
    if (mem_we === 1'b1) we_pulses++;
    n_checks++; if (cpu_rvalid !== 1'b1 || rd_data !== 16'hBEEF || dma_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_readback: got rvalid=%b data=%h dma_rvalid=%b exp 1 beef 0", cpu_rvalid, rd_data, dma_rvalid); end
    n_checks++; if (we_pulses !== 1) begin
      n_fail++; $display("FAIL wr_pulses: got %0d exp 1", we_pulses); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    @(negedge clk);
    dma_req = 1; dma_lock = 1; dma_addr = 8'h60;
    @(negedge clk);
    cpu_req = 1; cpu_addr = 8'h61; #1;
    n_checks++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1 || dma_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got dma=%b stall=%b dma_rvalid=%b exp 1 1 1", dma_gnt, cpu_stall, dma_rvalid); end
    #1 reset = 1'b1; #1;
    n_checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rvalid_clr: got dma=%b cpu=%b exp 0 0", dma_rvalid, cpu_rvalid); end
    n_checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_prio: got cpu=%b dma=%b exp 1 0", cpu_gnt, dma_gnt); end
    @(negedge clk); #1;
    n_checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_rvalid_held: got dma=%b cpu=%b exp 0 0", dma_rvalid, cpu_rvalid); end
    reset = 1'b0; #1;
    n_checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      n_fail++; $display("FAIL mid_first_grant: got cpu=%b dma=%b exp 1 0", cpu_gnt, dma_gnt); end
    @(negedge clk); #1;
    n_checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_post_rvalid: got cpu=%b dma=%b exp 1 0", cpu_rvalid, dma_rvalid); end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_contention();
    test_locked_burst();
    test_lock_drop();
    test_write_read();
    test_reset_mid_burst();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
